// File: rtl/reg_scoreboard_pkg.sv
// Shared core defines: register file geometry and watchdog states.
// Optional feature macro: REG_SCOREBOARD_WB_BYPASS_EN.
package reg_scoreboard_pkg;

  localparam int REG_COUNT    = 16;
  localparam int REG_SIZE     = 32;
  localparam int REG_PTR_SIZE = $clog2(REG_COUNT);

  typedef logic [REG_PTR_SIZE-1:0] reg_ptr_t;
  typedef logic [REG_COUNT-1:0]    reg_mask_t;
  typedef logic [REG_SIZE-1:0]     reg_data_t;

  typedef enum logic [1:0] {
    WD_RUN     = 2'd0,
    WD_STALLED = 2'd1,
    WD_HUNG    = 2'd2
  } wd_state_t;

  function automatic reg_mask_t ptr_onehot(reg_ptr_t p);
    return reg_mask_t'(1) << p;
  endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode/writeback bundle between the pipeline and the scoreboard.
// Optional feature macro: REG_SCOREBOARD_WB_BYPASS_EN.
interface reg_scoreboard_if;
  import reg_scoreboard_pkg::*;

  logic      FD_valid;
  reg_ptr_t  FD_insn_src_0;
  reg_ptr_t  FD_insn_src_1;
  logic      FD_src_0_used;
  logic      FD_src_1_used;
  logic      FD_dst_used;
  reg_ptr_t  FD_insn_dst;
  logic      MW_wb_valid;
  reg_ptr_t  MW_insn_dst;
  logic      init_R0;
  logic      flush;
  logic      stall;
  logic      issue;
  reg_mask_t busy_mask;
  logic      hang;
`ifdef REG_SCOREBOARD_WB_BYPASS_EN
  logic      wb_fwd_0;
  logic      wb_fwd_1;
`endif

  modport master (
    output FD_valid, FD_insn_src_0, FD_insn_src_1,
    output FD_src_0_used, FD_src_1_used,
    output FD_dst_used, FD_insn_dst,
    output MW_wb_valid, MW_insn_dst,
    output init_R0, flush,
`ifdef REG_SCOREBOARD_WB_BYPASS_EN
    input  wb_fwd_0, wb_fwd_1,
`endif
    input  stall, issue, busy_mask, hang
  );

  modport slave (
    input  FD_valid, FD_insn_src_0, FD_insn_src_1,
    input  FD_src_0_used, FD_src_1_used,
    input  FD_dst_used, FD_insn_dst,
    input  MW_wb_valid, MW_insn_dst,
    input  init_R0, flush,
`ifdef REG_SCOREBOARD_WB_BYPASS_EN
    output wb_fwd_0, wb_fwd_1,
`endif
    output stall, issue, busy_mask, hang
  );

endinterface

// File: rtl/reg_scoreboard_stall_watchdog.sv
// Counts consecutive stall cycles; sticky hang once the limit is hit.
// Cleared only by reset or flush.
module reg_scoreboard_stall_watchdog
  import reg_scoreboard_pkg::*;
#(
  parameter int STALL_LIMIT = 255,
  parameter int CNT_SIZE    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic stall,
  input  logic flush,
  output logic hang
);

  localparam logic [CNT_SIZE-1:0] CNT_MAX = '1;
  localparam logic [CNT_SIZE-1:0] LIMIT   = CNT_SIZE'(STALL_LIMIT);

  if (((64'(1) << CNT_SIZE) - 1) < 64'(STALL_LIMIT)) begin : g_bad_cnt
    $error("CNT_SIZE too small for STALL_LIMIT");
  end

  wd_state_t           state_q, state_d;
  logic [CNT_SIZE-1:0] cnt_q, cnt_d;

  // State and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= WD_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: count stall run, latch hang at the limit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = WD_RUN;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        WD_RUN: begin
          if (stall) begin
            cnt_d   = CNT_SIZE'(1);
            state_d = (cnt_d >= LIMIT) ? WD_HUNG
                                       : WD_STALLED;
          end
        end
        WD_STALLED: begin
          if (stall) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q
                                       : cnt_q + 1'b1;
            if (cnt_d >= LIMIT) state_d = WD_HUNG;
          end else begin
            state_d = WD_RUN;
            cnt_d   = '0;
          end
        end
        WD_HUNG: begin
          if (stall && cnt_q != CNT_MAX)
            cnt_d = cnt_q + 1'b1;
        end
        default: begin
          state_d = WD_RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output: hang is a pure decode of the registered state
  always_comb begin
    hang = (state_q == WD_HUNG);
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: RAW/WAW/init_R0 hazard stall plus hang watchdog.
// Optional feature macro: REG_SCOREBOARD_WB_BYPASS_EN (writeback bypass).
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int CORE_NUM    = 0,
  parameter int STALL_LIMIT = 255,
  parameter int CNT_SIZE    = 8
) (
  input logic             clk,
  input logic             reset,
  reg_scoreboard_if.slave sb
);

  if (CORE_NUM < 0) begin : g_bad_core
    $error("CORE_NUM must be non-negative");
  end

  reg_mask_t busy_q, busy_d;
  reg_mask_t wb_mask, set_mask, hz_mask;
  logic      raw0, raw1, waw, r0c;
  logic      stall_c, issue_c;
  logic      hang_w;

  // Writeback clear mask; with bypass it also hides the hazard
  always_comb begin
    wb_mask = sb.MW_wb_valid ? ptr_onehot(sb.MW_insn_dst)
                             : '0;
`ifdef REG_SCOREBOARD_WB_BYPASS_EN
    hz_mask = busy_q & ~wb_mask;
`else
    hz_mask = busy_q;
`endif
  end

  // Hazard detection and the zero-latency stall/issue decision
  always_comb begin
    raw0 = sb.FD_src_0_used & hz_mask[sb.FD_insn_src_0];
    raw1 = sb.FD_src_1_used & hz_mask[sb.FD_insn_src_1];
    waw  = sb.FD_dst_used & hz_mask[sb.FD_insn_dst];
    r0c  = sb.init_R0 &
           ((sb.FD_src_0_used & (sb.FD_insn_src_0 == '0)) |
            (sb.FD_src_1_used & (sb.FD_insn_src_1 == '0)) |
            (sb.FD_dst_used & (sb.FD_insn_dst == '0)));
    stall_c = sb.FD_valid & ~sb.flush &
              (raw0 | raw1 | waw | r0c);
    issue_c = sb.FD_valid & ~sb.flush & ~stall_c;
  end

  // Next busy vector: clear on writeback, then set on issue
  always_comb begin
    set_mask = (issue_c & sb.FD_dst_used)
             ? ptr_onehot(sb.FD_insn_dst) : '0;
    busy_d   = (busy_q & ~wb_mask) | set_mask;
  end

  // Busy register; flush drops every pending write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        busy_q <= '0;
    else if (sb.flush) busy_q <= '0;
    else               busy_q <= busy_d;
  end

  reg_scoreboard_stall_watchdog #(
    .STALL_LIMIT (STALL_LIMIT),
    .CNT_SIZE    (CNT_SIZE)
  ) u_stall_watchdog (
    .clk   (clk),
    .reset (reset),
    .stall (stall_c),
    .flush (sb.flush),
    .hang  (hang_w)
  );

  assign sb.stall     = stall_c;
  assign sb.issue     = issue_c;
  assign sb.busy_mask = busy_q;
  assign sb.hang      = hang_w;

`ifdef REG_SCOREBOARD_WB_BYPASS_EN
  assign sb.wb_fwd_0 = sb.FD_src_0_used & sb.MW_wb_valid &
                       (sb.MW_insn_dst == sb.FD_insn_src_0);
  assign sb.wb_fwd_1 = sb.FD_src_1_used & sb.MW_wb_valid &
                       (sb.MW_insn_dst == sb.FD_insn_src_1);
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed plus random test of reg_scoreboard against a reference model.
// Optional feature macro: REG_SCOREBOARD_WB_BYPASS_EN.
module tb_reg_scoreboard;

  localparam int LIMIT = 4;
  localparam int NREG  = 16;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  bit   m_busy [NREG];
  int   m_run;
  bit   m_hang;

  always #5 clk = ~clk;

  reg_scoreboard_if sb ();

  reg_scoreboard #(
    .CORE_NUM    (0),
    .STALL_LIMIT (LIMIT),
    .CNT_SIZE    (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb)
  );

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(bit v, int s0, bit u0, int s1, bit u1,
                       int d, bit du, bit wb, int wd,
                       bit init, bit fl);
    sb.FD_valid      = v;
    sb.FD_insn_src_0 = 4'(s0);
    sb.FD_src_0_used = u0;
    sb.FD_insn_src_1 = 4'(s1);
    sb.FD_src_1_used = u1;
    sb.FD_insn_dst   = 4'(d);
    sb.FD_dst_used   = du;
    sb.MW_wb_valid   = wb;
    sb.MW_insn_dst   = 4'(wd);
    sb.init_R0       = init;
    sb.flush         = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // One cycle: check outputs against model, clock, update model.
  task automatic step(string tag);
    bit h0, h1, hw, hr, e_st, e_is;
    bit [15:0] em;
    int s0, s1, d, wd;
    #1;
    s0 = int'(sb.FD_insn_src_0);
    s1 = int'(sb.FD_insn_src_1);
    d  = int'(sb.FD_insn_dst);
    wd = int'(sb.MW_insn_dst);
    h0 = sb.FD_src_0_used && m_busy[s0];
    h1 = sb.FD_src_1_used && m_busy[s1];
    hw = sb.FD_dst_used && m_busy[d];
`ifdef REG_SCOREBOARD_WB_BYPASS_EN
    if (sb.MW_wb_valid && wd == s0) h0 = 0;
    if (sb.MW_wb_valid && wd == s1) h1 = 0;
    if (sb.MW_wb_valid && wd == d)  hw = 0;
`endif
    hr = sb.init_R0 &&
         ((sb.FD_src_0_used && s0 == 0) ||
          (sb.FD_src_1_used && s1 == 0) ||
          (sb.FD_dst_used && d == 0));
    e_st = sb.FD_valid && !sb.flush && (h0 || h1 || hw || hr);
    e_is = sb.FD_valid && !sb.flush && !e_st;
    for (int i = 0; i < NREG; i++) em[i] = m_busy[i];
    chk({tag, "_stall"}, 32'(sb.stall), 32'(e_st));
    chk({tag, "_issue"}, 32'(sb.issue), 32'(e_is));
    chk({tag, "_busy"}, 32'(sb.busy_mask), 32'(em));
    chk({tag, "_hang"}, 32'(sb.hang), 32'(m_hang));
`ifdef REG_SCOREBOARD_WB_BYPASS_EN
    chk({tag, "_fwd0"}, 32'(sb.wb_fwd_0),
        32'(sb.FD_src_0_used && sb.MW_wb_valid && wd == s0));
    chk({tag, "_fwd1"}, 32'(sb.wb_fwd_1),
        32'(sb.FD_src_1_used && sb.MW_wb_valid && wd == s1));
`endif
    @(posedge clk);
    if (sb.flush) begin
      for (int i = 0; i < NREG; i++) m_busy[i] = 0;
      m_run  = 0;
      m_hang = 0;
    end else begin
      if (sb.MW_wb_valid) m_busy[wd] = 0;
      if (e_is && sb.FD_dst_used) m_busy[d] = 1;
      m_run = e_st ? m_run + 1 : 0;
      if (m_run >= LIMIT) m_hang = 1;
    end
    @(negedge clk);
  endtask

  initial begin
    int cand[$];
    int wd;
    reset = 1'b0;
    idle();
    for (int i = 0; i < NREG; i++) m_busy[i] = 0;
    m_run  = 0;
    m_hang = 0;
    #12;
    chk("rst_busy", 32'(sb.busy_mask), 32'h0);
    chk("rst_stall", 32'(sb.stall), 32'h0);
    chk("rst_issue", 32'(sb.issue), 32'h0);
    chk("rst_hang", 32'(sb.hang), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // RAW on r3
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
    step("raw_iss");
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("raw_stall1", 32'(sb.stall), 32'h1);
    chk("raw_busy3", 32'(sb.busy_mask[3]), 32'h1);
    step("raw_st");
    drive(1, 3, 1, 0, 0, 0, 0, 1, 3, 0, 0);
`ifndef REG_SCOREBOARD_WB_BYPASS_EN
    #1 chk("raw_nobyp", 32'(sb.stall), 32'h1);
`endif
    step("raw_wb");
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("raw_go", 32'(sb.issue), 32'h1);
    step("raw_go");

    // WAW on r5
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    step("waw_iss");
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    #1 chk("waw_stall", 32'(sb.stall), 32'h1);
    step("waw_st");
    drive(1, 0, 0, 0, 0, 5, 1, 1, 5, 0, 0);
    step("waw_wb");
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    #1 chk("waw_go", 32'(sb.issue), 32'h1);
    step("waw_go");
    idle();
    #1 chk("waw_reset", 32'(sb.busy_mask[5]), 32'h1);
    step("waw_idle");

    // Unused operand on busy r7
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
    step("unu_iss");
    drive(1, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("unu_issue", 32'(sb.issue), 32'h1);
    step("unu_go");

    // init_R0 blocks a reader of R0
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    #1 chk("r0_stall", 32'(sb.stall), 32'h1);
    step("r0_st");
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("r0_issue", 32'(sb.issue), 32'h1);
    step("r0_go");

    // Flush with busy 0x00F0 and a pending stall
    drive(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0);
    step("fl_c5");
    drive(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
    step("fl_c7");
    for (int r = 4; r < 8; r++) begin
      drive(1, 0, 0, 0, 0, r, 1, 0, 0, 0, 0);
      step("fl_set");
    end
    drive(1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("fl_mask", 32'(sb.busy_mask), 32'h00F0);
    step("fl_st");
    drive(1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    #1 chk("fl_issue", 32'(sb.issue), 32'h0);
    step("fl_do");
    idle();
    #1 chk("fl_busy0", 32'(sb.busy_mask), 32'h0);
    step("fl_after");

    // Watchdog: hang after LIMIT stall cycles, sticky
    drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0);
    step("wd_iss");
    for (int k = 1; k <= LIMIT; k++) begin
      drive(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      #1 chk("wd_nohang", 32'(sb.hang), 32'h0);
      step("wd_st");
    end
    drive(1, 9, 1, 0, 0, 0, 0, 1, 9, 0, 0);
    #1 chk("wd_hang", 32'(sb.hang), 32'h1);
    step("wd_wb");
    drive(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("wd_sticky", 32'(sb.hang), 32'h1);
    step("wd_go");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("wd_fl");
    idle();
    #1 chk("wd_clr", 32'(sb.hang), 32'h0);
    step("wd_clr");

`ifdef REG_SCOREBOARD_WB_BYPASS_EN
    drive(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0);
    step("byp_iss");
    drive(1, 2, 1, 0, 0, 0, 0, 1, 2, 0, 0);
    #1 chk("byp_issue", 32'(sb.issue), 32'h1);
    chk("byp_fwd0", 32'(sb.wb_fwd_0), 32'h1);
    step("byp_go");
`endif

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      cand.delete();
      for (int i = 0; i < NREG; i++)
        if (m_busy[i]) cand.push_back(i);
      wd = (cand.size() > 0 && $urandom_range(3) != 0)
         ? cand[$urandom_range(cand.size() - 1)]
         : int'($urandom_range(NREG - 1));
      drive($urandom_range(7) != 0,
            $urandom_range(NREG - 1), 1'($urandom),
            $urandom_range(NREG - 1), 1'($urandom),
            $urandom_range(NREG - 1), 1'($urandom),
            1'($urandom), wd,
            $urandom_range(9) == 0,
            $urandom_range(39) == 0);
      step("rnd");
    end

    // Reset mid-run loses all busy bits
    drive(1, 0, 0, 0, 0, 11, 1, 0, 0, 0, 0);
    step("mr_iss");
    reset = 1'b0;
    #1 chk("mr_busy", 32'(sb.busy_mask), 32'h0);
    chk("mr_hang", 32'(sb.hang), 32'h0);
    for (int i = 0; i < NREG; i++) m_busy[i] = 0;
    m_run  = 0;
    m_hang = 0;
    @(negedge clk);
    reset = 1'b1;
    idle();
    step("mr_after");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Per-core hazard controller for the register file.
- Tracks registers with outstanding writes, so decode (FD) never reads a stale value and never reorders two writes to the same register.
- Sits between decode and the register file. Consumes the FD source/destination pointers and the MW writeback pointer; produces the FD stall/issue and a hang flag.
- Also blocks any instruction that touches R0 while an init_R0 load is in progress.

Parameters:
- CORE_NUM, 0, core index; informational only (watchdog debug display).
- STALL_LIMIT, 255, number of consecutive stall cycles after which `hang` asserts.
- CNT_SIZE, 8, width of the stall counter; must satisfy 2^CNT_SIZE-1 >= STALL_LIMIT.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- FD_valid  in  1  decode holds an instruction.
- FD_insn_src_0  in  REG_PTR_SIZE  source 0 pointer.
- FD_insn_src_1  in  REG_PTR_SIZE  source 1 pointer.
- FD_src_0_used  in  1  src_0 is read by this format.
- FD_src_1_used  in  1  src_1 is read by this format.
- FD_dst_used  in  1  instruction writes a register.
- FD_insn_dst  in  REG_PTR_SIZE  destination pointer.
- MW_wb_valid  in  1  writeback this cycle.
- MW_insn_dst  in  REG_PTR_SIZE  writeback destination.
- init_R0  in  1  R0 is being overwritten by init this cycle.
- flush  in  1  pipeline flush; drop all pending writes.
- stall  out  1  FD must hold.
- issue  out  1  FD instruction accepted this cycle.
- busy_mask  out  REG_COUNT  bit i = register i has a pending write.
- hang  out  1  sticky watchdog flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - busy_mask=0, stall counter=0, hang=0.
  - Hence stall=0 and issue=0 while FD_valid=0.
- Hazards, evaluated combinationally in the current cycle:
  - raw0 = FD_src_0_used & busy[src_0]
  - raw1 = FD_src_1_used & busy[src_1]
  - waw = FD_dst_used & busy[dst]
  - r0c = init_R0 & ((FD_src_0_used & src_0==0) | (FD_src_1_used & src_1==0) | (FD_dst_used & dst==0))
- Outputs:
  - stall = FD_valid & ~flush & (raw0 | raw1 | waw | r0c)
  - issue = FD_valid & ~flush & ~stall
  - A same-cycle writeback does NOT clear a hazard (no bypass unless the feature below is enabled). The cleared bit is visible next cycle.
- Busy update at the clock edge:
  - If issue & FD_dst_used: busy[dst] <= 1.
  - If MW_wb_valid: busy[MW_insn_dst] <= 0.
  - Set and clear of the same register in one cycle cannot occur without bypass, because WAW stalls. With bypass enabled, set wins.
  - MW_wb_valid to a register that is not busy is ignored.
- Flush has priority over everything: busy_mask <= 0, counter <= 0, hang <= 0, and issue is forced to 0 that cycle.
- Watchdog FSM, 3 states:
  - RUN → STALLED when stall=1; counter starts at 1.
  - STALLED: counter increments each stall cycle, saturating at 2^CNT_SIZE-1. Returns to RUN with counter=0 when stall=0.
  - STALLED → HUNG when counter reaches STALL_LIMIT; hang=1, registered, one cycle after the limit cycle.
  - HUNG is left only by reset or flush; stall/issue keep working normally.
- Latency: busy_mask reflects an issue one cycle later; stall/issue have zero latency.
- Reset mid-stall: all busy bits are lost; the upstream pipeline must also be reset.

Optional Feature:
- Macro: REG_SCOREBOARD_WB_BYPASS_EN.
- Defined:
  - A hazard on register r is masked when MW_wb_valid & MW_insn_dst==r in the same cycle. Applies to raw0, raw1 and waw.
  - Adds output wb_fwd_0 / wb_fwd_1 (1 bit each): the read datapath selects W_result instead of the register-file output for that source.
  - If the masked WAW issues, the set wins over the clear.
- Undefined:
  - The behaviour above with no bypass; wb_fwd ports do not exist.

Decomposition:
- REG_COUNT, REG_SIZE and REG_PTR_SIZE come from the shared core defines header, the same one the register file uses; nothing is redefined locally.
- Watchdog state encodings (RUN/STALLED/HUNG) go in that header as `define constants.
- One natural sub-module, stall_watchdog: counter plus FSM, inputs stall and flush, output hang.

Test Plan:
- RAW: issue dst=3 (cycle 0); next cycle src_0=3 used → stall=1, busy_mask[3]=1. Writeback to 3 → stall=0 the following cycle, issue=1.
- WAW: dst=5 pending, new insn dst=5 with no sources → stall until writeback to 5. Then issue and busy[5] is set again.
- Unused operand: src_1=7 with busy[7]=1 but FD_src_1_used=0 → issue=1, no stall.
- init_R0: init_R0=1 while the insn reads R0 → stall=1. Next cycle init_R0=0 → issue=1.
- Flush: busy_mask=0x00F0 plus stall pending, flush=1 → issue=0, and busy_mask=0 / hang=0 next cycle.
- Watchdog: STALL_LIMIT=4, hold src busy with no writeback → hang=1 after the 4th stall cycle, and stays 1 after the writeback. Flush clears it.
- Bypass build: busy[2], src_0=2 used, writeback to 2 in the same cycle → issue=1, wb_fwd_0=1.
